shift_reg_universal: RTL

SHIFT_REG_UNIVERSAL -- requirements
Module: shift_reg_universal

---
 rtl/shift_reg_universal_if.sv | 31 +++
 rtl/shift_reg_universal.sv | 105 ++++++++++
 2 files changed

// File: rtl/shift_reg_universal_if.sv
// Bus bundle for shift_reg_universal.
// Master drives the operation controls and reads the register state.
// Slave is the register itself.
//   MODE   : operation select
//   DI     : parallel load data
//   SR_SER : serial input for shift right
//   SL_SER : serial input for shift left
//   START  : request a burst operation
//   COUNT  : number of burst steps
//   Q      : register contents
//   BUSY   : burst in progress
//   DONE   : one-cycle pulse at burst completion
interface shift_reg_universal_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [2:0]       MODE;
  logic [WIDTH-1:0] DI;
  logic             SR_SER;
  logic             SL_SER;
  logic             START;
  logic [CNT_W-1:0] COUNT;
  logic [WIDTH-1:0] Q;
  logic             BUSY;
  logic             DONE;

  modport master (output MODE, DI, SR_SER, SL_SER, START, COUNT,
                  input  Q, BUSY, DONE);
  modport slave  (input  MODE, DI, SR_SER, SL_SER, START, COUNT,
                  output Q, BUSY, DONE);
endinterface

// File: rtl/shift_reg_universal.sv
// Universal shift register with an optional multi-cycle burst mode.
// Immediate mode applies MODE once per clock. A START with a shifting or
// rotating MODE latches MODE/COUNT and then runs COUNT steps, one per
// clock, before pulsing DONE.
// Ports:
//   CLK : clock, rising edge
//   CLR : asynchronous active-low reset
//   bus : shift_reg_universal_if slave (MODE, DI, SR_SER, SL_SER, START,
//         COUNT in; Q, BUSY, DONE out)
module shift_reg_universal #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 CLK,
  input  logic                 CLR,
  shift_reg_universal_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One step of the selected operation. Bits move toward the MSB on
  // "right" operations (Q[i] <= Q[i-1]) and toward the LSB on "left".
  function automatic logic [WIDTH-1:0] step_op(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] q,
    input logic             sr,
    input logic             sl,
    input logic [WIDTH-1:0] di
  );
    case (m)
      3'b001:  step_op = {q[WIDTH-2:0], sr};
      3'b010:  step_op = {sl, q[WIDTH-1:1]};
      3'b011:  step_op = di;
      3'b100:  step_op = {q[WIDTH-2:0], q[WIDTH-1]};
      3'b101:  step_op = {q[0], q[WIDTH-1:1]};
      3'b110:  step_op = {q[WIDTH-1], q[WIDTH-1:1]};
      default: step_op = q;
    endcase
  endfunction

  // Only modes that move bits are worth running as a burst.
  function automatic logic is_burst(input logic [2:0] m);
    is_burst = (m == 3'b001) || (m == 3'b010) || (m == 3'b100) ||
               (m == 3'b101) || (m == 3'b110);
  endfunction

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      q_q     <= '0;
      mode_q  <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.START && is_burst(bus.MODE)) begin
          // Latch only; the first step happens on the next edge.
          mode_d  = bus.MODE;
          cnt_d   = bus.COUNT;
          state_d = (bus.COUNT != CNT_ZERO) ? RUN : FIN;
        end else begin
          q_d = step_op(bus.MODE, q_q, bus.SR_SER, bus.SL_SER, bus.DI);
        end
      end
      RUN: begin
        // Serial inputs stay live; everything else comes from the latch.
        q_d   = step_op(mode_q, q_q, bus.SR_SER, bus.SL_SER, bus.DI);
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decoded straight from state so reset clears them without a clock.
  assign bus.Q    = q_q;
  assign bus.BUSY = (state_q != IDLE);
  assign bus.DONE = (state_q == FIN);

endmodule
